uart_rx_fifo: RTL and testbench

- Receive-side buffer placed directly downstream of the Uart8 receiver.
- Captures each completed or errored frame from the receiver's rxDone/rxErr/rxOut outputs into a small FIFO. Each entry is tagged with a framing-error bit.
- Presents entries to the host logic through a show-ahead valid/ready interface.
- Keeps a sticky overflow flag and a saturating framing-error counter.

---
 rtl/uart_pkg.sv | 11 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 84 ++++++++
 tb/tb_uart_rx_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive path.
// A FIFO entry is one received byte plus its framing-error tag.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int ERRCNT_W    = 8;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock show-ahead FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap modulo DEPTH; count disambiguates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the Uart8 receiver: edge-captures frames into a FIFO,
// tracks dropped frames (sticky overflow) and counts framing errors.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  logic [UART_DATA_W-1:0] rxOut,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [UART_DATA_W-1:0] outByte,
  output logic                   outErr,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   overflow,
  input  logic                   clearOverflow,
  output logic [ERRCNT_W-1:0]    errCount
);
  logic      rx_done_q;
  logic      rx_err_q;
  logic      done_edge;
  logic      err_edge;
  logic      push;
  logic      pop;
  logic      drop;
  logic      empty;
  rx_entry_t wr_entry;
  rx_entry_t rd_entry;

  assign done_edge = rxDone & ~rx_done_q;
  assign err_edge  = rxErr & ~rx_err_q;
  assign push      = done_edge | err_edge;
  assign pop       = outValid & outReady;
  assign drop      = push & full & ~pop;
  assign wr_entry  = '{err: err_edge, data: rxOut};

  // Edge registers reset high so a level held through reset is not a new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_q <= 1'b1;
      rx_err_q  <= 1'b1;
    end else begin
      rx_done_q <= rxDone;
      rx_err_q  <= rxErr;
    end
  end

  sync_fifo #(
    .WIDTH  ($bits(rx_entry_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign outValid = ~empty;
  assign outByte  = outValid ? rd_entry.data : '0;
  assign outErr   = outValid & rd_entry.err;

  // A drop in the same cycle as clearOverflow keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      errCount <= '0;
    end else begin
      if (drop)               overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
      if (err_edge && errCount != '1) errCount <= errCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxOut;
  logic       outValid;
  logic       outReady;
  logic [7:0] outByte;
  logic       outErr;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clearOverflow;
  logic [7:0] errCount;

  int assertions = 0;
  int failures   = 0;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxDone        (rxDone),
    .rxErr         (rxErr),
    .rxOut         (rxOut),
    .outValid      (outValid),
    .outReady      (outReady),
    .outByte       (outByte),
    .outErr        (outErr),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .errCount      (errCount)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge, away from the capturing rising edge.
  task automatic applyStimulus(input logic done, input logic err, input logic [7:0] data,
                               input logic ready, input logic clr);
    @(negedge clk);
    rxDone        = done;
    rxErr         = err;
    rxOut         = data;
    outReady      = ready;
    clearOverflow = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pushFrame(input logic [7:0] data);
    applyStimulus(1'b1, 1'b0, data, 1'b0, 1'b0);
    idle();
  endtask

  task automatic popOne();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    assert (got === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    rxDone = 1'b0; rxErr = 1'b0; rxOut = 8'h00; outReady = 1'b0; clearOverflow = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
    idle();

    $display("[TB] reset state");
    checkOutput("rst_valid",    32'(outValid), 32'd0);
    checkOutput("rst_count",    32'(count),    32'd0);
    checkOutput("rst_full",     32'(full),     32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_errcount", 32'(errCount), 32'd0);
    checkOutput("rst_byte",     32'(outByte),  32'd0);
    checkOutput("rst_err",      32'(outErr),   32'd0);

    $display("[TB] single frame and pop");
    pushFrame(8'hD5);
    checkOutput("t1_valid", 32'(outValid), 32'd1);
    checkOutput("t1_byte",  32'(outByte),  32'hD5);
    checkOutput("t1_err",   32'(outErr),   32'd0);
    checkOutput("t1_count", 32'(count),    32'd1);
    popOne();
    checkOutput("t1_pop_count", 32'(count),    32'd0);
    checkOutput("t1_pop_valid", 32'(outValid), 32'd0);

    $display("[TB] rxDone held for five cycles");
    repeat (5) applyStimulus(1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
    idle();
    checkOutput("t2_count", 32'(count),   32'd1);
    checkOutput("t2_byte",  32'(outByte), 32'hA3);
    popOne();
    checkOutput("t2_empty", 32'(count), 32'd0);

    $display("[TB] framing error frame");
    applyStimulus(1'b0, 1'b1, 8'b11010101, 1'b0, 1'b0);
    idle();
    checkOutput("t3_count",    32'(count),    32'd1);
    checkOutput("t3_err",      32'(outErr),   32'd1);
    checkOutput("t3_byte",     32'(outByte),  32'hD5);
    checkOutput("t3_errcount", 32'(errCount), 32'd1);
    checkOutput("t3_overflow", 32'(overflow), 32'd0);
    popOne();
    checkOutput("t3_empty", 32'(count), 32'd0);

    $display("[TB] overflow with 17 frames");
    for (int i = 0; i <= 16; i++) pushFrame(8'(i));
    checkOutput("t4_count",    32'(count),    32'd16);
    checkOutput("t4_full",     32'(full),     32'd1);
    checkOutput("t4_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t4_order", 32'(outByte), 32'(i));
      popOne();
    end
    checkOutput("t4_drained", 32'(count),    32'd0);
    checkOutput("t4_novalid", 32'(outValid), 32'd0);
    checkOutput("t4_zerobyte", 32'(outByte), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    checkOutput("t4_clear", 32'(overflow), 32'd0);
    checkOutput("t4_errcount", 32'(errCount), 32'd1);

    $display("[TB] push and pop while full");
    for (int i = 0; i < 16; i++) pushFrame(8'h20 + 8'(i));
    checkOutput("t5_full",     32'(full),     32'd1);
    checkOutput("t5_overflow", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    idle();
    checkOutput("t5_count",    32'(count),    32'd16);
    checkOutput("t5_ovf_kept", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t5_order", 32'(outByte), (i < 15) ? 32'(8'h21 + 8'(i)) : 32'h55);
      popOne();
    end
    checkOutput("t5_drained", 32'(count), 32'd0);

    $display("[TB] simultaneous done and error, then reset");
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    idle();
    checkOutput("t6_count",    32'(count),    32'd1);
    checkOutput("t6_err",      32'(outErr),   32'd1);
    checkOutput("t6_byte",     32'(outByte),  32'h77);
    checkOutput("t6_errcount", 32'(errCount), 32'd2);
    pushFrame(8'h01);
    pushFrame(8'h02);
    checkOutput("t6_count3", 32'(count), 32'd3);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    rxDone = 1'b1;
    #1;
    checkOutput("t6_async_count", 32'(count),    32'd0);
    checkOutput("t6_async_valid", 32'(outValid), 32'd0);
    checkOutput("t6_async_errcnt", 32'(errCount), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    checkOutput("t6_held_count", 32'(count), 32'd0);
    idle();
    pushFrame(8'h3C);
    checkOutput("t6_after_count", 32'(count),   32'd1);
    checkOutput("t6_after_byte",  32'(outByte), 32'h3C);

    $display("[TB] errCount saturation");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
      idle();
    end
    checkOutput("sat_errcount", 32'(errCount), 32'd255);
    checkOutput("sat_overflow", 32'(overflow), 32'd1);
    checkOutput("sat_count",    32'(count),    32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
